// File: rtl/serial_borrow_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master modport is the producer/consumer side; the slave modport is the subtractor.
interface serial_borrow_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout
  );
endinterface

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial unsigned subtractor: {bout, d} = a - b - bin, one bit per clock, LSB first,
// behind valid/ready handshakes on the operand and result sides.
module serial_borrow_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_borrow_subtractor_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, d_q, d_acc, d_r;
  logic [IW-1:0]    idx;
  logic             brw, brw_next, bout_r;
  logic             a_bit, b_bit, diff_bit;
  logic             accept, in_ready, out_valid;

  assign accept = (state == IDLE) && bus.in_valid;

  // Full-subtractor cell on the current bit position.
  always_comb begin
    a_bit    = a_q[idx];
    b_bit    = b_q[idx];
    diff_bit = a_bit ^ b_bit ^ brw;
    brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    d_acc    = d_q;
    d_acc[idx] = diff_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = CALC;
      end
      CALC: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // d/bout live in their own registers so the last result survives the next
  // accept (which clears the accumulator) until a new result is ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      d_r    <= '0;
      brw    <= 1'b0;
      bout_r <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q <= bus.a;
            b_q <= bus.b;
            brw <= bus.bin;
            idx <= '0;
            d_q <= '0;
          end
        end
        CALC: begin
          d_q <= d_acc;
          brw <= brw_next;
          idx <= idx + IW'(1);
          if (idx == LAST) begin
            d_r    <= d_acc;
            bout_r <= brw_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.d         = d_r;
  assign bus.bout      = bout_r;
endmodule
